risc231_memio: RTL and testbench
================================

Name: risc231_memio

Overview:
- Data-side memory and memory-mapped I/O stage placed directly downstream of the RISC231 core.
- Consumes the core's mem_wr, mem_addr and mem_writedata outputs, and returns mem_readdata in the same cycle, as the single-cycle core requires.
- Contains the data RAM, a free-running cycle counter, an LED output register, and a small keyboard input FIFO with status.

Parameters:
- Dbits, 32, data word width.
- Nwords, 64, data RAM depth in words; power of two.
- Kdepth, 4, keyboard FIFO depth; power of two, minimum 2.

Ports:
- clk  input  1  processor clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  processor enable; gates all core-side state changes
- mem_wr  input  1  write strobe from core
- mem_addr  input  32  byte address from core
- mem_writedata  input  Dbits  store data from core
- mem_readdata  output  Dbits  load data to core; combinational
- key_valid  input  1  one-cycle pulse; a key code is present
- key_code  input  8  key code, sampled when key_valid=1
- led  output  16  LED register, low 16 bits

Behaviour:
- Address decode:
  - RAM region: mem_addr[31:16]=16'h1001; word index = mem_addr[2 +: log2(Nwords)].
  - IO region: mem_addr[31:16]=16'h1003; register offset = mem_addr[5:2].
  - mem_addr[1:0] is ignored.
  - Anything else is unmapped: reads return 0, writes are ignored.
- IO map (offset, name, access):
  - 0, CYCLES, RO.
  - 1, LED, RW.
  - 2, KEYDATA, RO: FIFO head, zero-extended; 0 when empty.
  - 3, KEYPOP, WO: any write pops the FIFO; reads return 0.
  - 4, KEYSTAT, R/W1C:
    - bit0 = nonempty; bit1 = full; bit2 = sticky overflow.
    - bits[7:4] = count, zero-extended.
    - A write with data bit2=1 clears overflow; other bits are ignored.
  - Offsets 5 to 15 read 0; writes to them are ignored.
- Write timing: a write takes effect on the rising clk edge where mem_wr=1, enable=1, and the address selects the target. Read data shows the new value in the following cycle.
- Reads: fully combinational from the current mem_addr. A read never changes state, so no read side effects.
- RAM: one write port, asynchronous read. Contents are not cleared by reset and are undefined after power-up.
- CYCLES:
  - Dbits-wide counter; +1 on every clk edge with enable=1; holds when enable=0.
  - Wraps from all-ones to 0.
  - Reset value 0, so the first enabled cycle after reset reads 0.
- LED: Dbits register, reset 0; led = LED[15:0].
- Keyboard FIFO:
  - Circular buffer with read pointer, write pointer and count (log2(Kdepth)+1 bits).
  - Push happens when key_valid=1 and either count<Kdepth or a pop occurs in the same cycle. Push is independent of enable.
  - A pop request is a KEYPOP write. It is honoured only if count>0; a pop of an empty FIFO is a no-op.
  - Simultaneous push and pop: both take effect and count is unchanged. This also applies when full: the head is removed and the new code is accepted.
  - Push when full with no pop: the code is dropped and overflow is set (sticky).
  - If an overflow clear and a new overflow occur in the same cycle, set wins.
  - Pointers wrap modulo Kdepth.
- Reset, including mid-operation: clears CYCLES, LED, FIFO pointers, count and overflow. Outputs after reset: led=0; mem_readdata follows decode of the current address. A key_valid asserted in the reset cycle is discarded.

Test Plan:
- Reset then read: assert reset for 2 cycles, then read 0x10030000 on the first enabled cycle -> 0; 5 enabled cycles later -> 5. Drop enable for 3 cycles -> value holds. Read 0x10030010 -> 0.
- RAM store/load: write 0xDEADBEEF to 0x10010008 and 0x12345678 to 0x100100FC (Nwords=64). Readback of each returns its value. Read 0x10010009 -> 0xDEADBEEF (low bits ignored). Write with enable=0 -> no change.
- LED and unmapped: write 0x0001A5A5 to 0x10030004 -> led=0xA5A5 and readback=0x0001A5A5. Write to 0x20000000 or 0x10030018 -> no state change; reads of both return 0.
- FIFO order and empty: push 0x41, 0x42 -> KEYSTAT=0x21 and KEYDATA=0x41. Pop -> KEYDATA=0x42. Pop -> KEYSTAT=0x00 and KEYDATA=0. Third pop -> no-op; count stays 0.
- FIFO full and overflow: push 0x10..0x13 -> KEYSTAT=0x43. Push 0x14 -> KEYSTAT=0x47 and head still 0x10. Write 0x4 to KEYSTAT -> 0x43. Push 0x15 together with a pop -> KEYSTAT=0x43, head=0x11, tail entry=0x15.
- Reset mid-operation: with 3 keys queued, LED=0xFF and CYCLES=100, assert reset with key_valid=1 -> afterwards KEYSTAT=0, led=0, CYCLES restarts at 0, and RAM data written earlier is still readable.

Source files
------------

// File: rtl/risc231_memio_if.sv
// RISC231 data-side bus: the core drives address, strobe and store data,
// and the memory/IO stage returns load data in the same cycle.
interface risc231_memio_if #(
  parameter int Dbits = 32
);
  logic             mem_wr;
  logic [31:0]      mem_addr;
  logic [Dbits-1:0] mem_writedata;
  logic [Dbits-1:0] mem_readdata;

  modport master (
    output mem_wr,
    output mem_addr,
    output mem_writedata,
    input  mem_readdata
  );

  modport slave (
    input  mem_wr,
    input  mem_addr,
    input  mem_writedata,
    output mem_readdata
  );
endinterface

// File: rtl/risc231_memio.sv
// RISC231 data memory and memory-mapped IO: data RAM, cycle counter,
// LED register and a keyboard FIFO with status/overflow.
module risc231_memio #(
  parameter int Dbits  = 32,
  parameter int Nwords = 64,
  parameter int Kdepth = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  risc231_memio_if.slave bus,
  input  logic           key_valid,
  input  logic [7:0]     key_code,
  output logic [15:0]    led
);
  localparam int AW = $clog2(Nwords);
  localparam int KW = $clog2(Kdepth);
  localparam logic [KW:0] KFULL = (KW+1)'(Kdepth);
  localparam logic [KW:0] CONE = (KW+1)'(1);
  localparam logic [KW-1:0] PONE = KW'(1);

  logic [Dbits-1:0] ram [Nwords];
  logic [7:0]       kfifo [Kdepth];
  logic [Dbits-1:0] cycles;
  logic [Dbits-1:0] led_q;
  logic [KW-1:0]    rd_ptr;
  logic [KW-1:0]    wr_ptr;
  logic [KW:0]      count;
  logic             ovf;

  logic             ram_sel;
  logic             io_sel;
  logic             wr_en;
  logic [3:0]       off;
  logic [AW-1:0]    widx;
  logic             kempty;
  logic             kfull;
  logic             pop;
  logic             push;
  logic             ovf_set;
  logic             ovf_clr;
  logic [Dbits-1:0] stat;
  logic             unused_addr;

  assign ram_sel = bus.mem_addr[31:16] == 16'h1001;
  assign io_sel  = bus.mem_addr[31:16] == 16'h1003;
  assign off     = bus.mem_addr[5:2];
  assign widx    = bus.mem_addr[2 +: AW];
  assign wr_en   = bus.mem_wr & enable;

  assign unused_addr = ^{bus.mem_addr[1:0],
                         bus.mem_addr[15:6]};

  assign kempty = count == '0;
  assign kfull  = count == KFULL;

  // A pop frees a slot, so a same-cycle push is accepted even when full.
  assign pop     = wr_en & io_sel & (off == 4'd3)
                 & ~kempty;
  assign push    = key_valid & (~kfull | pop);
  assign ovf_set = key_valid & kfull & ~pop;
  assign ovf_clr = wr_en & io_sel & (off == 4'd4)
                 & bus.mem_writedata[2];

  assign led = led_q[15:0];

  always_comb begin
    stat      = '0;
    stat[0]   = ~kempty;
    stat[1]   = kfull;
    stat[2]   = ovf;
    stat[7:4] = 4'(count);
  end

  always_comb begin
    bus.mem_readdata = '0;
    unique case (1'b1)
      ram_sel: bus.mem_readdata = ram[widx];
      io_sel: begin
        case (off)
          4'd0: bus.mem_readdata = cycles;
          4'd1: bus.mem_readdata = led_q;
          4'd2: bus.mem_readdata = kempty ? '0
                : Dbits'(kfifo[rd_ptr]);
          4'd4: bus.mem_readdata = stat;
          default: bus.mem_readdata = '0;
        endcase
      end
      default: bus.mem_readdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles <= '0;
      led_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (enable)
        cycles <= cycles + Dbits'(1);
      if (wr_en & io_sel & (off == 4'd1))
        led_q <= bus.mem_writedata;
      if (pop)
        rd_ptr <= rd_ptr + PONE;
      if (push)
        wr_ptr <= wr_ptr + PONE;
      if (push & ~pop)
        count <= count + CONE;
      else if (pop & ~push)
        count <= count - CONE;
      // A new overflow beats a same-cycle clear.
      if (ovf_set)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push & ~reset)
      kfifo[wr_ptr] <= key_code;
    if (wr_en & ram_sel)
      ram[widx] <= bus.mem_writedata;
  end
endmodule

// File: tb/tb_risc231_memio.sv
// Testbench for risc231_memio: directed vector table, reset sequence,
// and randomized traffic against a queue-based reference model.
module tb_risc231_memio;
  localparam int DB = 32;
  localparam int NW = 64;
  localparam int KD = 4;
  localparam logic [31:0] A_CY  = 32'h1003_0000;
  localparam logic [31:0] A_LED = 32'h1003_0004;
  localparam logic [31:0] A_KD  = 32'h1003_0008;
  localparam logic [31:0] A_KP  = 32'h1003_000C;
  localparam logic [31:0] A_KS  = 32'h1003_0010;
  localparam logic [15:0] L     = 16'hA5A5;

  typedef struct {
    bit          r;
    bit          e;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    bit          kv;
    logic [7:0]  kc;
    bit          c;
    logic [31:0] xr;
    logic [15:0] xl;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [15:0] led;

  int checks = 0;
  int failures = 0;

  risc231_memio_if #(.Dbits(DB)) bus ();

  risc231_memio #(
    .Dbits(DB), .Nwords(NW), .Kdepth(KD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bus.slave),
    .key_valid(key_valid),
    .key_code(key_code),
    .led(led)
  );

  always #5 clk = ~clk;

  // Reference model state
  int unsigned m_cyc;
  logic [31:0] m_led;
  logic [31:0] m_ram [NW];
  logic [7:0]  m_q [$];
  bit          m_ovf;

  function automatic logic [31:0] m_read(
    input logic [31:0] a);
    int n;
    n = m_q.size();
    if (a[31:16] == 16'h1001)
      return m_ram[a[7:2]];
    if (a[31:16] != 16'h1003)
      return 32'h0;
    case (a[5:2])
      4'd0: return m_cyc;
      4'd1: return m_led;
      4'd2: return (n > 0) ? {24'h0, m_q[0]} : 32'h0;
      4'd4: return {24'h0, 4'(n), 1'b0, m_ovf,
                    n == KD, n != 0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    bit io_w;
    logic [3:0] o;
    logic [7:0] tmp;
    io_w = enable && bus.mem_wr
        && bus.mem_addr[31:16] == 16'h1003;
    o = bus.mem_addr[5:2];
    if (reset) begin
      m_cyc = 0;
      m_led = 0;
      m_q.delete();
      m_ovf = 0;
    end else begin
      if (io_w && o == 4'd3 && m_q.size() > 0)
        tmp = m_q.pop_front();
      if (io_w && o == 4'd4 && bus.mem_writedata[2])
        m_ovf = 0;
      if (key_valid) begin
        if (m_q.size() < KD) m_q.push_back(key_code);
        else m_ovf = 1;
      end
      if (io_w && o == 4'd1) m_led = bus.mem_writedata;
      if (enable) m_cyc = m_cyc + 1;
    end
    if (enable && bus.mem_wr
        && bus.mem_addr[31:16] == 16'h1001)
      m_ram[bus.mem_addr[7:2]] = bus.mem_writedata;
  endtask

  task automatic drive(input bit r, input bit e,
                       input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit kv,
                       input logic [7:0] kc);
    @(negedge clk);
    reset = r;
    enable = e;
    bus.mem_wr = w;
    bus.mem_addr = a;
    bus.mem_writedata = d;
    key_valid = kv;
    key_code = kc;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit e, bit w,
    logic [31:0] a, logic [31:0] d, bit kv,
    logic [7:0] kc, bit c, logic [31:0] xr,
    logic [15:0] xl);
    vec_t v;
    v.r = r; v.e = e; v.w = w; v.a = a; v.d = d;
    v.kv = kv; v.kc = kc; v.c = c; v.xr = xr; v.xl = xl;
    return v;
  endfunction

  function automatic vec_t rv(logic [31:0] a,
    logic [31:0] xr, logic [15:0] xl);
    return mk(0, 1, 0, a, 0, 0, 0, 1, xr, xl);
  endfunction

  function automatic vec_t wv(logic [31:0] a,
    logic [31:0] d, logic [31:0] xr, logic [15:0] xl);
    return mk(0, 1, 1, a, d, 0, 0, 1, xr, xl);
  endfunction

  vec_t tv [$];

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    bit r, e, w, kv;
    int sel;

    reset = 1; enable = 0; key_valid = 0; key_code = 0;
    bus.mem_wr = 0; bus.mem_addr = 0;
    bus.mem_writedata = 0;

    // Reset and cycle counter
    tv.push_back(mk(1, 1, 0, A_CY, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, A_CY, 0, 1, 8'h99, 1, 0, 0));
    for (int i = 0; i < 6; i++)
      tv.push_back(rv(A_CY, i, 0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 0, A_CY, 0, 0, 0, 1, 6, 0));
    tv.push_back(rv(A_KS, 0, 0));
    // RAM
    tv.push_back(mk(0, 1, 1, 32'h1001_0008, 32'hDEADBEEF,
                    0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 32'h1001_00FC, 32'h12345678,
                    0, 0, 0, 0, 0));
    tv.push_back(rv(32'h1001_0008, 32'hDEADBEEF, 0));
    tv.push_back(rv(32'h1001_00FC, 32'h12345678, 0));
    tv.push_back(rv(32'h1001_0009, 32'hDEADBEEF, 0));
    tv.push_back(mk(0, 0, 1, 32'h1001_0008, 0,
                    0, 0, 1, 32'hDEADBEEF, 0));
    tv.push_back(rv(32'h1001_0008, 32'hDEADBEEF, 0));
    // LED and unmapped
    tv.push_back(wv(A_LED, 32'h0001A5A5, 0, 0));
    tv.push_back(rv(A_LED, 32'h0001A5A5, L));
    tv.push_back(wv(32'h2000_0000, '1, 0, L));
    tv.push_back(wv(32'h1003_0018, '1, 0, L));
    tv.push_back(wv(32'h1002_0008, 0, 0, L));
    tv.push_back(rv(32'h2000_0000, 0, L));
    tv.push_back(rv(32'h1003_0018, 0, L));
    tv.push_back(rv(32'h1001_0008, 32'hDEADBEEF, L));
    tv.push_back(rv(A_LED, 32'h0001A5A5, L));
    // FIFO order and empty
    tv.push_back(mk(0, 1, 0, A_KS, 0, 1, 8'h41, 1, 0, L));
    tv.push_back(mk(0, 1, 0, A_KS, 0, 1, 8'h42, 1, 32'h11, L));
    tv.push_back(rv(A_KS, 32'h21, L));
    tv.push_back(rv(A_KD, 32'h41, L));
    tv.push_back(wv(A_KP, 0, 0, L));
    tv.push_back(rv(A_KD, 32'h42, L));
    tv.push_back(wv(A_KP, 0, 0, L));
    tv.push_back(rv(A_KS, 0, L));
    tv.push_back(rv(A_KD, 0, L));
    tv.push_back(wv(A_KP, 0, 0, L));
    tv.push_back(rv(A_KS, 0, L));
    // FIFO full and overflow
    tv.push_back(mk(0, 1, 0, A_KS, 0, 1, 8'h10, 1, 32'h00, L));
    tv.push_back(mk(0, 1, 0, A_KS, 0, 1, 8'h11, 1, 32'h11, L));
    tv.push_back(mk(0, 1, 0, A_KS, 0, 1, 8'h12, 1, 32'h21, L));
    tv.push_back(mk(0, 1, 0, A_KS, 0, 1, 8'h13, 1, 32'h31, L));
    tv.push_back(mk(0, 1, 0, A_KS, 0, 1, 8'h14, 1, 32'h43, L));
    tv.push_back(rv(A_KS, 32'h47, L));
    tv.push_back(rv(A_KD, 32'h10, L));
    tv.push_back(wv(A_KS, 32'h4, 32'h47, L));
    tv.push_back(rv(A_KS, 32'h43, L));
    tv.push_back(mk(0, 1, 1, A_KP, 0, 1, 8'h15, 1, 0, L));
    tv.push_back(rv(A_KS, 32'h43, L));
    tv.push_back(rv(A_KD, 32'h11, L));
    tv.push_back(mk(0, 1, 1, A_KS, 4, 1, 8'h16, 1, 32'h43, L));
    tv.push_back(rv(A_KS, 32'h47, L));
    tv.push_back(wv(A_KS, 32'hFFFF_FFFB, 32'h47, L));
    tv.push_back(rv(A_KS, 32'h47, L));
    tv.push_back(wv(A_KS, 32'h4, 32'h47, L));
    tv.push_back(rv(A_KS, 32'h43, L));
    tv.push_back(mk(0, 0, 1, A_KP, 0, 0, 0, 1, 0, L));
    tv.push_back(rv(A_KS, 32'h43, L));
    for (int i = 0; i < 3; i++)
      tv.push_back(wv(A_KP, 0, 0, L));
    tv.push_back(rv(A_KD, 32'h15, L));
    tv.push_back(rv(A_KS, 32'h11, L));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].r, tv[i].e, tv[i].w, tv[i].a,
            tv[i].d, tv[i].kv, tv[i].kc);
      if (tv[i].c) begin
        chk($sformatf("vec%0d_rd", i),
            bus.mem_readdata, tv[i].xr);
        chk($sformatf("vec%0d_led", i),
            {16'h0, led}, {16'h0, tv[i].xl});
      end
      tick();
    end

    // Reset in the middle of operation
    drive(1, 1, 0, A_CY, 0, 0, 0);
    tick();
    for (int i = 0; i <= 100; i++) begin
      if (i == 3) begin
        drive(0, 1, 1, A_LED, 32'hFF, 0, 0);
        chk("mid_led_pre", bus.mem_readdata, 0);
      end else begin
        drive(0, 1, 0, A_CY, 0, i < 3,
              8'(8'h61 + i));
        chk($sformatf("mid_cyc%0d", i),
            bus.mem_readdata, i);
      end
      tick();
    end
    drive(1, 1, 0, A_KS, 0, 1, 8'h77);
    chk("mid_ks_pre", bus.mem_readdata, 32'h31);
    chk("mid_led_pre", {16'h0, led}, 32'hFF);
    tick();
    drive(0, 1, 0, A_CY, 0, 0, 0);
    chk("mid_cyc_restart", bus.mem_readdata, 0);
    chk("mid_led_clr", {16'h0, led}, 0);
    tick();
    drive(0, 1, 0, A_KS, 0, 0, 0);
    chk("mid_ks_clr", bus.mem_readdata, 0);
    tick();
    drive(0, 1, 0, 32'h1001_0008, 0, 0, 0);
    chk("mid_ram0", bus.mem_readdata, 32'hDEADBEEF);
    tick();
    drive(0, 1, 0, 32'h1001_00FC, 0, 0, 0);
    chk("mid_ram1", bus.mem_readdata, 32'h12345678);
    tick();

    // Randomized traffic against the model
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < NW; i++) begin
      drive(0, 1, 1, 32'h1001_0000 | (i << 2),
            $urandom, 0, 0);
      tick();
    end
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199) == 0;
      e = $urandom_range(0, 9) != 0;
      w = $urandom_range(0, 1) == 1;
      kv = $urandom_range(0, 4) == 0;
      sel = $urandom_range(0, 9);
      if (sel < 3)
        a = {16'h1001, 16'($urandom)};
      else if (sel < 9)
        a = {16'h1003, 10'($urandom),
             4'($urandom_range(0, 7)), 2'($urandom)};
      else
        a = $urandom;
      d = $urandom;
      drive(r, e, w, a, d, kv, 8'($urandom));
      chk("rand_rd", bus.mem_readdata, m_read(a));
      chk("rand_led", {16'h0, led},
          {16'h0, m_led[15:0]});
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
